// File: rtl/hub75_line_fetch.sv
// Fills one line-buffer half from one framebuffer row, metered through the colormap handshake.
// Optional HUB75_LINE_FETCH_MIRROR_EN adds ctrl_mirror to write columns in reverse order.
module hub75_line_fetch #(
  parameter int LOG_N_ROWS = 5,
  parameter int LOG_N_COLS = 6,
  parameter int BITDEPTH   = 24,
  parameter int N_CHANS    = 3,
  parameter int N_PLANES   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [LOG_N_ROWS-1:0]            ctrl_row,
  input  logic                             ctrl_buf,
  input  logic                             ctrl_go,
`ifdef HUB75_LINE_FETCH_MIRROR_EN
  input  logic                             ctrl_mirror,
`endif
  output logic                             ctrl_rdy,
  output logic                             ctrl_done,
  output logic [LOG_N_ROWS+LOG_N_COLS-1:0] fb_rd_addr,
  output logic                             fb_rd_en,
  input  logic [BITDEPTH-1:0]              fb_rd_data,
  output logic [BITDEPTH-1:0]              cm_in_data,
  output logic [LOG_N_COLS-1:0]            cm_in_user,
  output logic                             cm_in_valid,
  input  logic                             cm_in_ready,
  input  logic [N_CHANS*N_PLANES-1:0]      cm_out_data,
  input  logic [LOG_N_COLS-1:0]            cm_out_user,
  input  logic                             cm_out_valid,
  output logic [LOG_N_COLS:0]              lb_wr_addr,
  output logic [N_CHANS*N_PLANES-1:0]      lb_wr_data,
  output logic                             lb_wr_ena
);

  localparam int N_COLS = 1 << LOG_N_COLS;
  localparam int CW     = LOG_N_COLS + 1;
  localparam int PW     = N_CHANS * N_PLANES;
  localparam int EW     = LOG_N_COLS + BITDEPTH;
  localparam logic [CW-1:0] LAST_COL = CW'(N_COLS - 1);
  localparam logic [CW-1:0] TERM_CNT = CW'(N_COLS);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [LOG_N_ROWS-1:0]   row_q, row_d;
  logic                    buf_q, buf_d;
  logic [CW-1:0]           fetch_cnt_q, fetch_cnt_d;
  logic [CW-1:0]           wr_cnt_q, wr_cnt_d;
  logic                    inflight_q, inflight_d;
  logic [LOG_N_COLS-1:0]   inflight_col_q, inflight_col_d;
  logic [EW-1:0]           mem_q [2];
  logic [EW-1:0]           mem_d [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              fifo_cnt_q, fifo_cnt_d;
  logic                    lb_ena_q, lb_ena_d;
  logic [LOG_N_COLS:0]     lb_addr_q, lb_addr_d;
  logic [PW-1:0]           lb_data_q, lb_data_d;
`ifdef HUB75_LINE_FETCH_MIRROR_EN
  logic                    mirror_q, mirror_d;
`endif

  logic                    go_acc;
  logic                    credit;
  logic                    rd_issue;
  logic                    push;
  logic                    pop;
  logic                    wr_take;
  logic [LOG_N_COLS-1:0]   wr_col;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (ctrl_go) state_d = ST_FETCH;
      ST_FETCH: if (rd_issue && fetch_cnt_q == LAST_COL) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_cnt_q == TERM_CNT) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Credit counts both queued and in-flight reads so the 2-entry FIFO can never overflow
  always_comb begin
    credit    = (fifo_cnt_q + 2'(inflight_q)) < 2'd2;
    ctrl_rdy  = (state_q == ST_IDLE);
    ctrl_done = (state_q == ST_DONE);
    rd_issue  = (state_q == ST_FETCH) && credit;
    fb_rd_en  = rd_issue;
  end

  always_comb begin
    go_acc         = (state_q == ST_IDLE) && ctrl_go;
    row_d          = go_acc ? ctrl_row : row_q;
    buf_d          = go_acc ? ctrl_buf : buf_q;
    fetch_cnt_d    = fetch_cnt_q;
    if (go_acc)        fetch_cnt_d = '0;
    else if (rd_issue) fetch_cnt_d = fetch_cnt_q + 1'b1;
    inflight_d     = rd_issue;
    inflight_col_d = fetch_cnt_q[LOG_N_COLS-1:0];

    push       = inflight_q;
    pop        = cm_in_valid && cm_in_ready;
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = {inflight_col_q, fb_rd_data};
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);

`ifdef HUB75_LINE_FETCH_MIRROR_EN
    mirror_d = go_acc ? ctrl_mirror : mirror_q;
    wr_col   = mirror_q ? ~cm_out_user : cm_out_user;
`else
    wr_col   = cm_out_user;
`endif

    wr_take  = cm_out_valid && (state_q == ST_FETCH || state_q == ST_DRAIN);
    wr_cnt_d = wr_cnt_q;
    if (go_acc)       wr_cnt_d = '0;
    else if (wr_take) wr_cnt_d = wr_cnt_q + 1'b1;
    lb_ena_d  = wr_take;
    lb_addr_d = wr_take ? {buf_q, wr_col} : lb_addr_q;
    lb_data_d = wr_take ? cm_out_data : lb_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q          <= '0;
      buf_q          <= 1'b0;
      fetch_cnt_q    <= '0;
      wr_cnt_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_col_q <= '0;
      mem_q[0]       <= '0;
      mem_q[1]       <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fifo_cnt_q     <= '0;
      lb_ena_q       <= 1'b0;
      lb_addr_q      <= '0;
      lb_data_q      <= '0;
`ifdef HUB75_LINE_FETCH_MIRROR_EN
      mirror_q       <= 1'b0;
`endif
    end else begin
      row_q          <= row_d;
      buf_q          <= buf_d;
      fetch_cnt_q    <= fetch_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      inflight_q     <= inflight_d;
      inflight_col_q <= inflight_col_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_cnt_q     <= fifo_cnt_d;
      lb_ena_q       <= lb_ena_d;
      lb_addr_q      <= lb_addr_d;
      lb_data_q      <= lb_data_d;
`ifdef HUB75_LINE_FETCH_MIRROR_EN
      mirror_q       <= mirror_d;
`endif
    end
  end

  always_comb begin
    fb_rd_addr  = {row_q, fetch_cnt_q[LOG_N_COLS-1:0]};
    cm_in_valid = (fifo_cnt_q != 2'd0);
    cm_in_data  = mem_q[rd_ptr_q][BITDEPTH-1:0];
    cm_in_user  = mem_q[rd_ptr_q][EW-1:BITDEPTH];
    lb_wr_ena   = lb_ena_q;
    lb_wr_addr  = lb_addr_q;
    lb_wr_data  = lb_data_q;
  end

endmodule

// File: tb/tb_hub75_line_fetch.sv
// Directed bench for hub75_line_fetch with LOG_N_COLS=3, a framebuffer model and a 4-cycle colormap model.
module tb_hub75_line_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ctrl_row;
  logic        ctrl_buf;
  logic        ctrl_go;
  logic        ctrl_mirror;
  logic        ctrl_rdy;
  logic        ctrl_done;
  logic [7:0]  fb_rd_addr;
  logic        fb_rd_en;
  logic [23:0] fb_rd_data = '0;
  logic [23:0] cm_in_data;
  logic [2:0]  cm_in_user;
  logic        cm_in_valid;
  logic        cm_in_ready;
  logic [23:0] cm_out_data;
  logic [2:0]  cm_out_user;
  logic        cm_out_valid;
  logic [3:0]  lb_wr_addr;
  logic [23:0] lb_wr_data;
  logic        lb_wr_ena;

  hub75_line_fetch #(
    .LOG_N_ROWS(5),
    .LOG_N_COLS(3),
    .BITDEPTH(24),
    .N_CHANS(3),
    .N_PLANES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_row(ctrl_row),
    .ctrl_buf(ctrl_buf),
    .ctrl_go(ctrl_go),
`ifdef HUB75_LINE_FETCH_MIRROR_EN
    .ctrl_mirror(ctrl_mirror),
`endif
    .ctrl_rdy(ctrl_rdy),
    .ctrl_done(ctrl_done),
    .fb_rd_addr(fb_rd_addr),
    .fb_rd_en(fb_rd_en),
    .fb_rd_data(fb_rd_data),
    .cm_in_data(cm_in_data),
    .cm_in_user(cm_in_user),
    .cm_in_valid(cm_in_valid),
    .cm_in_ready(cm_in_ready),
    .cm_out_data(cm_out_data),
    .cm_out_user(cm_out_user),
    .cm_out_valid(cm_out_valid),
    .lb_wr_addr(lb_wr_addr),
    .lb_wr_data(lb_wr_data),
    .lb_wr_ena(lb_wr_ena)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [23:0] fb_xor = '0;

  // Framebuffer: pixel = 0x010101*col, xor'd per line so lines are distinguishable
  always @(posedge clk)
    if (fb_rd_en) fb_rd_data <= 24'(32'h010101 * 32'(fb_rd_addr[2:0])) ^ fb_xor;

  // Colormap: accepts one pixel every 4th cycle, returns it unchanged one cycle later
  logic [1:0] cm_ph;
  assign cm_in_ready = (cm_ph == 2'd3);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cm_ph        <= '0;
      cm_out_valid <= 1'b0;
      cm_out_data  <= '0;
      cm_out_user  <= '0;
    end else begin
      cm_ph        <= cm_ph + 2'd1;
      cm_out_valid <= cm_in_valid && cm_in_ready;
      cm_out_data  <= cm_in_data;
      cm_out_user  <= cm_in_user;
    end
  end

  // Observers: line buffer image, read log, event counts, write-latency errors
  logic [23:0] lb [16];
  logic [7:0]  rd_log [128];
  int          n_reads = 0;
  int          n_wr = 0;
  int          n_done = 0;
  int          lat_err = 0;
  logic        cmv_d1 = 1'b0;
  always @(posedge clk) begin
    if (fb_rd_en && n_reads < 128) rd_log[n_reads] <= fb_rd_addr;
    if (fb_rd_en) n_reads <= n_reads + 1;
    if (lb_wr_ena) begin
      lb[lb_wr_addr] <= lb_wr_data;
      n_wr <= n_wr + 1;
    end
    if (ctrl_done) n_done <= n_done + 1;
    if (!rst && (lb_wr_ena !== cmv_d1)) lat_err <= lat_err + 1;
    cmv_d1 <= cm_out_valid && !rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_line(input logic [4:0] r, input logic b, input logic m, input logic [23:0] x);
    fb_xor      = x;
    ctrl_row    = r;
    ctrl_buf    = b;
    ctrl_mirror = m;
    ctrl_go     = 1'b1;
    @(negedge clk);
    ctrl_go     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output logic last_ena);
    cyc      = 0;
    last_ena = 1'b0;
    while (!ctrl_done && cyc < budget) begin
      last_ena = lb_wr_ena;
      @(negedge clk);
      cyc++;
    end
  endtask

  int          cyc;
  logic        last_ena;
  int          b_rd, b_wr, b_done, b_rd2;
  logic [23:0] pix;

  initial begin
    rst = 1'b1; ctrl_go = 1'b0; ctrl_row = '0; ctrl_buf = 1'b0; ctrl_mirror = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_strobes", {27'd0, ctrl_rdy, ctrl_done, fb_rd_en, cm_in_valid, lb_wr_ena}, 32'b10000);
    chk("rst_addrs", {20'd0, fb_rd_addr, lb_wr_addr}, 32'd0);
    chk("rst_lb_data", {8'd0, lb_wr_data}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_strobes", {27'd0, ctrl_rdy, ctrl_done, fb_rd_en, cm_in_valid, lb_wr_ena}, 32'b10000);
    end

    // Line A: row 5 into half 1, with a go pulse for row 2 while busy
    b_rd = n_reads; b_wr = n_wr; b_done = n_done;
    start_line(5'd5, 1'b1, 1'b0, 24'h0);
    chk("A_first_rd", {30'd0, ctrl_rdy, fb_rd_en}, 32'b01);
    chk("A_first_addr", {24'd0, fb_rd_addr}, 32'h28);
    repeat (10) @(negedge clk);
    ctrl_row = 5'd2; ctrl_go = 1'b1;
    @(negedge clk);
    ctrl_go = 1'b0;
    wait_done(60, cyc, last_ena);
    chk("A_done", {31'd0, ctrl_done}, 32'd1);
    chk("A_done_after_last_wr", {31'd0, last_ena}, 32'd1);
    chk("A_line_time_le40", {31'd0, (12 + cyc) <= 40}, 32'd1);
    @(negedge clk);
    chk("A_done_pulse_rdy", {30'd0, ctrl_done, ctrl_rdy}, 32'b01);
    repeat (6) @(negedge clk);
    chk("A_reads", n_reads - b_rd, 32'd8);
    chk("A_writes", n_wr - b_wr, 32'd8);
    chk("A_dones", n_done - b_done, 32'd1);
    chk("A_idle_after", {31'd0, ctrl_rdy}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("A_rd_addr", {24'd0, rd_log[b_rd + k]}, 32'h28 + k);
      pix = 24'(32'h010101 * k);
      chk("A_lb", {8'd0, lb[8 + k]}, {8'd0, pix});
    end

    // Line B into half 0, then line C into half 1 back-to-back
    b_rd = n_reads;
    start_line(5'd3, 1'b0, 1'b0, 24'hA00000);
    wait_done(60, cyc, last_ena);
    chk("B_done", {31'd0, ctrl_done}, 32'd1);
    chk("B_line_time_le40", {31'd0, (1 + cyc) <= 40}, 32'd1);
    @(negedge clk);
    chk("B_rdy_returns", {30'd0, ctrl_done, ctrl_rdy}, 32'b01);
    b_rd2 = n_reads;
    start_line(5'd4, 1'b1, 1'b0, 24'h0A0000);
    chk("C_first_rd", {31'd0, fb_rd_en}, 32'd1);
    wait_done(60, cyc, last_ena);
    chk("C_done", {31'd0, ctrl_done}, 32'd1);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("B_rd_addr", {24'd0, rd_log[b_rd + k]}, 32'h18 + k);
      chk("C_rd_addr", {24'd0, rd_log[b_rd2 + k]}, 32'h20 + k);
      pix = 24'(32'h010101 * k) ^ 24'hA00000;
      chk("B_lb_half0", {8'd0, lb[k]}, {8'd0, pix});
      pix = 24'(32'h010101 * k) ^ 24'h0A0000;
      chk("C_lb_half1", {8'd0, lb[8 + k]}, {8'd0, pix});
    end

    // Line D: asynchronous reset after the third write
    b_wr = n_wr;
    start_line(5'd7, 1'b0, 1'b0, 24'h550000);
    for (int i = 0; i < 60 && (n_wr - b_wr) < 3; i++) @(negedge clk);
    chk("D_third_wr", n_wr - b_wr, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("D_rst_strobes", {27'd0, ctrl_rdy, ctrl_done, fb_rd_en, cm_in_valid, lb_wr_ena}, 32'b10000);
    @(negedge clk);
    rst = 1'b0;

    // Line E: go on the first edge after release, full line into half 0
    b_rd = n_reads; b_wr = n_wr; b_done = n_done;
    start_line(5'd6, 1'b0, 1'b0, 24'h0F0000);
    chk("E_first_rd", {23'd0, fb_rd_en, fb_rd_addr}, 32'h130);
    wait_done(60, cyc, last_ena);
    chk("E_done", {31'd0, ctrl_done}, 32'd1);
    chk("E_line_time_le40", {31'd0, (1 + cyc) <= 40}, 32'd1);
    @(negedge clk);
    chk("E_writes", n_wr - b_wr, 32'd8);
    chk("E_dones", n_done - b_done, 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("E_rd_addr", {24'd0, rd_log[b_rd + k]}, 32'h30 + k);
      pix = 24'(32'h010101 * k) ^ 24'h0F0000;
      chk("E_lb", {8'd0, lb[k]}, {8'd0, pix});
    end

`ifdef HUB75_LINE_FETCH_MIRROR_EN
    b_rd = n_reads;
    start_line(5'd1, 1'b0, 1'b1, 24'h300000);
    wait_done(60, cyc, last_ena);
    chk("F_done", {31'd0, ctrl_done}, 32'd1);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("F_rd_addr", {24'd0, rd_log[b_rd + k]}, 32'h08 + k);
      pix = 24'(32'h010101 * k) ^ 24'h300000;
      chk("F_lb_mirror", {8'd0, lb[7 - k]}, {8'd0, pix});
    end
`endif

    chk("wr_latency_errs", lat_err, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
